// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution RAM port arbiter.
package conv_pkg;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_STAT_W = 8;

    // Requester indices into the req/gnt vectors
    localparam int P0 = 0;   // pixel loader
    localparam int P1 = 1;   // convolution engine

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_ARB   = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, the port that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);
    // Port 0 wins when alone or when port 1 won last; otherwise port 1 if requesting
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_gnt))
            gnt[0] = 1'b1;
        else if (req[1])
            gnt[1] = 1'b1;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and clear sequencer in front of the 4x4 convolution RAM.
// Optional grant counters are built when RAM_ARB_STATS_EN is defined.
module ram_port_arbiter
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
`ifdef RAM_ARB_STATS_EN
  , parameter int STAT_W = DEF_STAT_W
`endif
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clear_req,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
`ifdef RAM_ARB_STATS_EN
    output logic [STAT_W-1:0] m0_gnt_cnt,
    output logic [STAT_W-1:0] m1_gnt_cnt,
`endif
    output logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_we,
    output logic              ram_clr,
    input  logic [DATA_W-1:0] ram_data_out
);
    arb_state_e        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic [1:0]        req, pick, gnt;

    assign req = {m1_req, m0_req};

    rr_arb2 u_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt      (pick)
    );

    // Next state, grant and RAM pin muxing; clear always pre-empts requests
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt         = 2'b00;
        ram_clr     = 1'b0;
        ram_we      = 1'b0;
        ram_address = '0;
        ram_data_in = '0;
        case (state_q)
            S_CLEAR: begin
                ram_clr = 1'b1;
                state_d = S_ARB;
            end
            S_ARB: begin
                if (clear_req) state_d = S_CLEAR;
                else           gnt     = pick;
            end
            default: state_d = S_CLEAR;
        endcase
        if (gnt[P0]) begin
            ram_we      = m0_we;
            ram_address = m0_addr;
            ram_data_in = m0_wdata;
            last_gnt_d  = 1'b0;
        end else if (gnt[P1]) begin
            ram_we      = m1_we;
            ram_address = m1_addr;
            ram_data_in = m1_wdata;
            last_gnt_d  = 1'b1;
        end
    end

    // Read return: capture RAM data at the grant edge, rdata holds otherwise
    always_comb begin
        rvalid_d[P0] = gnt[P0] & ~m0_we;
        rvalid_d[P1] = gnt[P1] & ~m1_we;
        m0_rdata_d   = rvalid_d[P0] ? ram_data_out : m0_rdata_q;
        m1_rdata_d   = rvalid_d[P1] ? ram_data_out : m1_rdata_q;
    end

    // State and read-return registers; reset parks in S_CLEAR so the RAM is wiped
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= S_CLEAR;
            last_gnt_q <= 1'b1;
            rvalid_q   <= 2'b00;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rvalid_q   <= rvalid_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_gnt    = gnt[P0];
    assign m1_gnt    = gnt[P1];
    assign m0_rvalid = rvalid_q[P0];
    assign m1_rvalid = rvalid_q[P1];
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

`ifdef RAM_ARB_STATS_EN
    logic [STAT_W-1:0] m0_cnt_q, m0_cnt_d, m1_cnt_q, m1_cnt_d;

    // Saturating grant counters, wiped whenever the RAM is cleared
    always_comb begin
        m0_cnt_d = m0_cnt_q;
        m1_cnt_d = m1_cnt_q;
        if (state_q == S_CLEAR) begin
            m0_cnt_d = '0;
            m1_cnt_d = '0;
        end else begin
            if (gnt[P0] && (m0_cnt_q != '1)) m0_cnt_d = m0_cnt_q + 1'b1;
            if (gnt[P1] && (m1_cnt_q != '1)) m1_cnt_d = m1_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            m0_cnt_q <= '0;
            m1_cnt_q <= '0;
        end else begin
            m0_cnt_q <= m0_cnt_d;
            m1_cnt_q <= m1_cnt_d;
        end
    end

    assign m0_gnt_cnt = m0_cnt_q;
    assign m1_gnt_cnt = m1_cnt_q;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural 4x4 RAM attached.
module tb_ram_port_arbiter;
    logic       clk = 1'b0;
    logic       clr_n, clear_req;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [1:0] m0_addr, m1_addr;
    logic [3:0] m0_wdata, m1_wdata;
    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [3:0] m0_rdata, m1_rdata;
    logic [3:0] ram_data_in, ram_data_out;
    logic [1:0] ram_address;
    logic       ram_we, ram_clr;
`ifdef RAM_ARB_STATS_EN
    logic [7:0] m0_gnt_cnt, m1_gnt_cnt;
`endif

    int         n_chk = 0;
    int         n_err = 0;
    logic       mon_en = 1'b0;
    logic [3:0] exp_mem [4];
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] ram_mem [4];

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .clr_n(clr_n), .clear_req(clear_req),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef RAM_ARB_STATS_EN
        .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt),
`endif
        .ram_data_in(ram_data_in), .ram_address(ram_address), .ram_we(ram_we),
        .ram_clr(ram_clr), .ram_data_out(ram_data_out)
    );

    // Behavioural RAM: combinational read, write/clear at the clock edge
    assign ram_data_out = ram_mem[ram_address];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 4; i++) ram_mem[i] <= 4'h0;
        end else if (ram_we) begin
            ram_mem[ram_address] <= ram_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Read-return checker: every rvalid must match the oldest expected read
    always @(negedge clk) begin
        if (mon_en) begin
            chk("excl", 32'(m0_gnt & m1_gnt), 32'd0);
            if (m0_rvalid === 1'b1) begin
                if (q0.size() == 0) chk("rv0_spurious", 32'd1, 32'd0);
                else                chk("rd0", 32'(m0_rdata), 32'(q0.pop_front()));
            end
            if (m1_rvalid === 1'b1) begin
                if (q1.size() == 0) chk("rv1_spurious", 32'd1, 32'd0);
                else                chk("rd1", 32'(m1_rdata), 32'(q1.pop_front()));
            end
        end
    end

    // One cycle: check grant and RAM pins against expectation, log expected reads
    task automatic step(input logic [1:0] exp_gnt, input logic exp_clr, input string tag);
        logic       e_we;
        logic [1:0] e_addr;
        logic [3:0] e_din;
        @(negedge clk);
        e_we = 1'b0; e_addr = 2'd0; e_din = 4'd0;
        if (exp_gnt[0]) begin
            e_we = m0_we; e_addr = m0_addr; e_din = m0_wdata;
            if (m0_we) exp_mem[m0_addr] = m0_wdata;
            else       q0.push_back(exp_mem[m0_addr]);
        end else if (exp_gnt[1]) begin
            e_we = m1_we; e_addr = m1_addr; e_din = m1_wdata;
            if (m1_we) exp_mem[m1_addr] = m1_wdata;
            else       q1.push_back(exp_mem[m1_addr]);
        end
        chk({tag, "_gnt"}, 32'({m1_gnt, m0_gnt}), 32'(exp_gnt));
        chk({tag, "_clr"}, 32'(ram_clr), 32'(exp_clr));
        chk({tag, "_we"}, 32'(ram_we), 32'(e_we));
        chk({tag, "_addr"}, 32'(ram_address), 32'(e_addr));
        if (e_we || exp_gnt == 2'b00) chk({tag, "_din"}, 32'(ram_data_in), 32'(e_din));
        if (exp_clr) for (int i = 0; i < 4; i++) exp_mem[i] = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 2'd0; m0_wdata = 4'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 2'd0; m1_wdata = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wv [4];
        wv[0] = 4'hA; wv[1] = 4'h5; wv[2] = 4'hF; wv[3] = 4'h3;
        for (int i = 0; i < 4; i++) exp_mem[i] = 4'h0;
        idle_inputs();
        clr_n = 1'b0;

        // 1: reset state, one clear cycle after release, then idle arbitration
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        chk("rst_rdata", 32'({m1_rdata, m0_rdata}), 32'd0);
        chk("rst_clr", 32'(ram_clr), 32'd1);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_pins", 32'({ram_address, ram_data_in}), 32'd0);
        clr_n = 1'b1;
        step(2'b00, 1'b1, "rel");
        step(2'b00, 1'b0, "idle");

        // 2: loader writes four words, engine reads them back
        for (int i = 0; i < 4; i++) begin
            m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'(i); m0_wdata = wv[i];
            step(2'b01, 1'b0, "wr");
        end
        m0_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'(i);
            step(2'b10, 1'b0, "rd");
        end
        // read directly after a write to the same address sees the new data
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'd2; m0_wdata = 4'h7;
        step(2'b01, 1'b0, "raw_wr");
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd2;
        step(2'b10, 1'b0, "raw_rd");
        m1_req = 1'b0;
        step(2'b00, 1'b0, "flush2");
        chk("q_empty2", 32'(q0.size() + q1.size()), 32'd0);

        // 3: both ports read every cycle -> strict alternation starting at port 0
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 2'd0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd1;
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, "alt");

        // 4: held clear request beats both requesters and alternates with S_CLEAR
        clear_req = 1'b1;
        step(2'b00, 1'b0, "clrq_arb");
        step(2'b00, 1'b1, "clrq_clr");
        step(2'b00, 1'b0, "clrq_arb2");
        step(2'b00, 1'b1, "clrq_clr2");
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'(i);
            step(2'b10, 1'b0, "rd_clr");
        end
        m1_req = 1'b0;
        step(2'b00, 1'b0, "flush4");
        chk("q_empty4", 32'(q0.size() + q1.size()), 32'd0);

        // 5: reset sampled at the edge that ends a read grant drops that return
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd1;
        @(negedge clk);
        chk("rst_mid_gnt", 32'({m1_gnt, m0_gnt}), 32'b10);
        clr_n = 1'b0;
        m1_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_mid_clr", 32'(ram_clr), 32'd1);
        chk("rst_mid_we", 32'(ram_we), 32'd0);
        clr_n = 1'b1;
        step(2'b00, 1'b1, "rel2");
        step(2'b00, 1'b0, "idle2");
        // first tie after reset goes to port 0
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 2'd3;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2'd0;
        step(2'b01, 1'b0, "tie0");
        m0_req = 1'b0;
        step(2'b10, 1'b0, "tie1");
        m1_req = 1'b0;
        step(2'b00, 1'b0, "flush5");
        chk("q_empty5", 32'(q0.size() + q1.size()), 32'd0);

`ifdef RAM_ARB_STATS_EN
        // 6: counter saturation
        chk("cnt0_start", 32'(m0_gnt_cnt), 32'd1);
        chk("cnt1_start", 32'(m1_gnt_cnt), 32'd1);
        m0_req = 1'b1; m0_we = 1'b1;
        for (int i = 0; i < 300; i++) begin
            m0_addr = 2'(i); m0_wdata = 4'(i);
            step(2'b01, 1'b0, "sat");
        end
        m0_req = 1'b0;
        chk("cnt0_sat", 32'(m0_gnt_cnt), 32'hFF);
        chk("cnt1_hold", 32'(m1_gnt_cnt), 32'd1);
        clear_req = 1'b1;
        step(2'b00, 1'b0, "cnt_clrq");
        clear_req = 1'b0;
        step(2'b00, 1'b1, "cnt_clr");
        chk("cnt0_zero", 32'(m0_gnt_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
